intersection_ctrl: RTL and testbench
====================================

Name: intersection_ctrl

Overview:
- Scheduler for two three-aspect signal heads, North-South (NS) and East-West (EW), that sequences their phases from fixed cycle budgets.
- Grants a shared pedestrian all-red WALK interval on request.
- Sits above the existing single-head `lights` unit in the lab signal-control design, and drives the same 3-bit light encoding.
- Only one direction may ever be non-red.

Parameters:
- GREEN_CYCLES, 8, cycles each green phase lasts (>=1)
- YELLOW_CYCLES, 3, cycles each yellow phase lasts (>=1)
- ALLRED_CYCLES, 2, cycles of all-red clearance after each yellow (>=1)
- WALK_CYCLES, 6, cycles of pedestrian WALK, all heads red (>=1)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level enable; 1 = run the cycle, 0 = park in all-red
- PedReq  input  1  pedestrian request; held high until PedAck
- PedAck  output  1  one-cycle pulse when WALK is granted
- Walk  output  1  pedestrian WALK indication
- NsLights  output  3  NS head, bit[2]=Red, [1]=Yellow, [0]=Green
- EwLights  output  3  EW head, same encoding
- Busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (Reset=1 at a rising edge):
  - state=IDLE; NsLights=EwLights=3'b100; Walk=0; PedAck=0; Busy=0.
  - PedPending=0; NextDir=NS; timer=0.
  - Applies mid-phase too: all-red on the cycle after the reset edge.
- States: IDLE, NS_GREEN, NS_YELLOW, ALLRED, EW_GREEN, EW_YELLOW, WALK.
- Outputs are registered and decoded from state:
  - NS_GREEN: Ns=001.
  - NS_YELLOW: Ns=010.
  - EW_GREEN: Ew=001.
  - EW_YELLOW: Ew=010.
  - All other states: both heads 100.
  - Walk=1 only in WALK.
- Timer:
  - On entry to a timed state it loads (duration-1).
  - It decrements each cycle and the state exits on the cycle it reads 0.
  - Each phase therefore lasts exactly its parameter in cycles.
  - Timer width is $clog2 of the largest parameter plus 1.
- IDLE: when Start=1 is sampled, move to NsGreen/EwGreen per NextDir (NS after reset), starting the next cycle.
- Transitions:
  - NS_GREEN -> NS_YELLOW -> ALLRED, which sets NextDir=EW.
  - EW_GREEN -> EW_YELLOW -> ALLRED, which sets NextDir=NS.
  - Green and yellow cannot be shortened or extended.
- ALLRED exit priority, evaluated at timer 0:
  1. Start=0 -> IDLE.
  2. Otherwise PedPending=1 -> WALK.
  3. Otherwise -> green of NextDir.
- WALK:
  - On entry, PedAck pulses for 1 cycle and PedPending clears.
  - On exit -> ALLRED (timer reloaded), then normal priority resumes.
  - NextDir is unchanged by WALK.
- PedPending:
  - Set when PedReq=1 and PedAck=0; sticky.
  - A PedReq held across the ack cycle does not re-arm. A new request requires PedReq to drop then rise.
  - Survives Start=0/IDLE; cleared only by reset or the WALK grant.
- Start=0 mid-phase: the current phase completes through yellow and ALLRED, then goes to IDLE. There is no abrupt red.
- Start=0 and PedPending=1 at the same ALLRED exit: IDLE wins. On restart from IDLE, if PedPending=1, go to WALK before the green of NextDir.
- Safety invariant: never (Ns!=100 && Ew!=100), and Walk=1 implies both heads are 100.

Decomposition:
- Shared package/include `intersection_pkg`:
  - state encodings;
  - light constants LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001;
  - direction constants DIR_NS=0, DIR_EW=1.
- Sub-module `phase_timer`:
  - parameterised width;
  - ports: Clk, Reset, Load, LoadVal, Done;
  - loadable down-counter with a Done flag at 0.
- The FSM, pedestrian latch and output decode remain in intersection_ctrl.

Test Plan:
- Reset then hold Start=0 for 20 cycles -> both heads 100, Busy=0, Walk=0 throughout.
- Start=1 at cycle 0 (defaults) -> NS green cycles 1-8, NS yellow 9-11, all-red 12-13, EW green 14-21, EW yellow 22-24, all-red 25-26, NS green from 27; the invariant holds every cycle.
- PedReq raised at cycle 5 and held until ack -> PedAck pulses at cycle 14, Walk=1 cycles 14-19, all-red 20-21, EW green from 22; no second WALK while PedReq stays high.
- Start dropped at cycle 3 -> NS green continues to 8, yellow 9-11, all-red 12-13, IDLE at 14. Start=1 again -> EW green first.
- Start=0 and PedPending=1 at the same ALLRED exit -> IDLE. After re-Start, WALK precedes the green, with PedAck pulsing once.
- Reset asserted for one cycle during EW_GREEN -> both heads 100 and Walk=0 next cycle, PedPending cleared, next Start begins with NS green.

Source files
------------

// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared state, light and direction constants for intersection_ctrl
package intersection_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_NS_GREEN  = 3'd1;
  localparam logic [2:0] ST_NS_YELLOW = 3'd2;
  localparam logic [2:0] ST_ALLRED    = 3'd3;
  localparam logic [2:0] ST_EW_GREEN  = 3'd4;
  localparam logic [2:0] ST_EW_YELLOW = 3'd5;
  localparam logic [2:0] ST_WALK      = 3'd6;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [2:0] green_state(input logic dir);
    return (dir == DIR_EW) ? ST_EW_GREEN : ST_NS_GREEN;
  endfunction

  function automatic logic [2:0] ns_light(input logic [2:0] st);
    case (st)
      ST_NS_GREEN:  return LIGHT_GRN;
      ST_NS_YELLOW: return LIGHT_YEL;
      default:      return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_light(input logic [2:0] st);
    case (st)
      ST_EW_GREEN:  return LIGHT_GRN;
      ST_EW_YELLOW: return LIGHT_YEL;
      default:      return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter flagging Done while it reads zero
module phase_timer #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  output logic         Done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = LoadVal;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Done = (count_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - two-head intersection phase scheduler with pedestrian WALK grant
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       PedReq,
  output logic       PedAck,
  output logic       Walk,
  output logic [2:0] NsLights,
  output logic [2:0] EwLights,
  output logic       Busy
);

  localparam int TW = $clog2(max4(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES)) + 1;

  logic [2:0]    state_q, state_d;
  logic          next_dir_q, next_dir_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_block_q, ped_block_d;
  logic          ped_ack_q, ped_ack_d;
  logic          walk_q, walk_d;
  logic          busy_q, busy_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic          grant;
  logic          timer_load;
  logic          timer_done;
  logic [TW-1:0] timer_val;

  phase_timer #(.W(TW)) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (timer_load),
    .LoadVal (timer_val),
    .Done    (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      ST_IDLE:      if (Start) state_d = ped_pend_q ? ST_WALK : green_state(next_dir_q);
      ST_NS_GREEN:  if (timer_done) state_d = ST_NS_YELLOW;
      ST_NS_YELLOW: if (timer_done) begin
                      state_d    = ST_ALLRED;
                      next_dir_d = DIR_EW;
                    end
      ST_EW_GREEN:  if (timer_done) state_d = ST_EW_YELLOW;
      ST_EW_YELLOW: if (timer_done) begin
                      state_d    = ST_ALLRED;
                      next_dir_d = DIR_NS;
                    end
      // A stopped controller parks before serving a pending walk; restart serves it first.
      ST_ALLRED:    if (timer_done) begin
                      if (!Start)          state_d = ST_IDLE;
                      else if (ped_pend_q) state_d = ST_WALK;
                      else                 state_d = green_state(next_dir_q);
                    end
      ST_WALK:      if (timer_done) state_d = ST_ALLRED;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign grant      = (state_d == ST_WALK) && (state_q != ST_WALK);
  assign timer_load = (state_d != state_q) && (state_d != ST_IDLE);

  always_comb begin
    timer_val = '0;
    case (state_d)
      ST_NS_GREEN, ST_EW_GREEN:   timer_val = TW'(GREEN_CYCLES - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: timer_val = TW'(YELLOW_CYCLES - 1);
      ST_ALLRED:                  timer_val = TW'(ALLRED_CYCLES - 1);
      ST_WALK:                    timer_val = TW'(WALK_CYCLES - 1);
      default:                    timer_val = '0;
    endcase
  end

  // ped_block keeps a request held through its own grant from re-arming until it drops.
  always_comb begin
    ped_pend_d  = ped_pend_q;
    ped_block_d = ped_block_q;
    if (!PedReq) ped_block_d = 1'b0;
    if (PedReq && !ped_ack_q && !ped_block_q) ped_pend_d = 1'b1;
    if (grant) begin
      ped_pend_d  = 1'b0;
      ped_block_d = 1'b1;
    end
    ped_ack_d = grant;
    ns_d      = ns_light(state_d);
    ew_d      = ew_light(state_d);
    walk_d    = (state_d == ST_WALK);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      next_dir_q  <= DIR_NS;
      ped_pend_q  <= 1'b0;
      ped_block_q <= 1'b0;
      ped_ack_q   <= 1'b0;
      walk_q      <= 1'b0;
      busy_q      <= 1'b0;
      ns_q        <= LIGHT_RED;
      ew_q        <= LIGHT_RED;
    end else begin
      state_q     <= state_d;
      next_dir_q  <= next_dir_d;
      ped_pend_q  <= ped_pend_d;
      ped_block_q <= ped_block_d;
      ped_ack_q   <= ped_ack_d;
      walk_q      <= walk_d;
      busy_q      <= busy_d;
      ns_q        <= ns_d;
      ew_q        <= ew_d;
    end
  end

  assign PedAck   = ped_ack_q;
  assign Walk     = walk_q;
  assign NsLights = ns_q;
  assign EwLights = ew_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - bench for intersection_ctrl: phase model plus directed cycle checks
module tb_intersection_ctrl;

  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 2;
  localparam int W = 6;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       PedReq = 1'b0;
  logic       PedAck;
  logic       Walk;
  logic [2:0] NsLights;
  logic [2:0] EwLights;
  logic       Busy;

  intersection_ctrl #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .ALLRED_CYCLES (A),
    .WALK_CYCLES   (W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .PedReq   (PedReq),
    .PedAck   (PedAck),
    .Walk     (Walk),
    .NsLights (NsLights),
    .EwLights (EwLights),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
  endtask

  // Model: a phase is what the road shows; m_left counts the cycles it still has to show it.
  typedef enum int {P_OFF, P_GO, P_WARN, P_CLEAR, P_XING} mph_t;
  mph_t m_ph = P_OFF;
  bit   m_ew = 0, m_next_ew = 0, m_pend = 0, m_hold = 0, m_ack = 0, m_valid = 0;
  int   m_left = 0;
  bit   was_pend, was_ack, grant;

  always @(posedge Clk) begin
    if (Reset) begin
      m_ph = P_OFF; m_left = 0; m_next_ew = 0; m_pend = 0; m_hold = 0; m_ack = 0; m_valid = 1;
    end else if (m_valid) begin
      was_pend = m_pend;
      was_ack  = m_ack;
      grant    = 0;
      m_ack    = 0;
      if (PedReq && !was_ack && !m_hold) m_pend = 1;
      if (!PedReq) m_hold = 0;
      case (m_ph)
        P_OFF: if (Start) begin
          if (was_pend) grant = 1;
          else begin m_ph = P_GO; m_ew = m_next_ew; m_left = G; end
        end
        P_GO:   if (m_left == 1) begin m_ph = P_WARN; m_left = Y; end else m_left--;
        P_WARN: if (m_left == 1) begin m_ph = P_CLEAR; m_left = A; m_next_ew = !m_ew; end
                else m_left--;
        P_CLEAR: if (m_left == 1) begin
          if (!Start) m_ph = P_OFF;
          else if (was_pend) grant = 1;
          else begin m_ph = P_GO; m_ew = m_next_ew; m_left = G; end
        end else m_left--;
        P_XING: if (m_left == 1) begin m_ph = P_CLEAR; m_left = A; end else m_left--;
        default: m_ph = P_OFF;
      endcase
      if (grant) begin
        m_ph = P_XING; m_left = W; m_pend = 0; m_hold = 1; m_ack = 1;
      end
    end
  end

  function automatic int exp_head(input bit is_ew);
    if (m_ph == P_GO && m_ew == is_ew)   return 3'b001;
    if (m_ph == P_WARN && m_ew == is_ew) return 3'b010;
    return 3'b100;
  endfunction

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("model_ns", NsLights, exp_head(0));
      chk("model_ew", EwLights, exp_head(1));
      chk("model_walk", Walk, (m_ph == P_XING) ? 1 : 0);
      chk("model_ack", PedAck, m_ack ? 1 : 0);
      chk("model_busy", Busy, (m_ph != P_OFF) ? 1 : 0);
      chk("safety", ((NsLights != 3'b100 && EwLights != 3'b100) ||
                     (Walk && (NsLights != 3'b100 || EwLights != 3'b100))) ? 1 : 0, 0);
    end
  end

  int cyc = 0;
  int ack_cnt = 0;

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge Clk);
      cyc++;
      if (PedAck) ack_cnt++;
    end
  endtask

  // One reset edge; returns on the negedge where the reset state is visible, as cycle 0.
  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; PedReq = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    cyc = 0;
    ack_cnt = 0;
  endtask

  initial begin
    @(negedge Clk);
    do_reset();
    chk("rst_ns", NsLights, 3'b100);
    chk("rst_ew", EwLights, 3'b100);
    chk("rst_busy", Busy, 0);
    chk("rst_walk", Walk, 0);
    goto(20);
    chk("idle_busy_c20", Busy, 0);
    chk("idle_ns_c20", NsLights, 3'b100);

    // Free-running cycle with defaults.
    do_reset();
    Start = 1'b1;
    goto(1);  chk("s2_ns_c1", NsLights, 3'b001);
    goto(8);  chk("s2_ns_c8", NsLights, 3'b001);
    goto(9);  chk("s2_ns_c9", NsLights, 3'b010);
    goto(11); chk("s2_ns_c11", NsLights, 3'b010);
    goto(12); chk("s2_ns_c12", NsLights, 3'b100);
    goto(13); chk("s2_ew_c13", EwLights, 3'b100);
    goto(14); chk("s2_ew_c14", EwLights, 3'b001);
    goto(21); chk("s2_ew_c21", EwLights, 3'b001);
    goto(22); chk("s2_ew_c22", EwLights, 3'b010);
    goto(25); chk("s2_ew_c25", EwLights, 3'b100);
    goto(27); chk("s2_ns_c27", NsLights, 3'b001);

    // Pedestrian request held well past its grant.
    do_reset();
    Start = 1'b1;
    goto(5);  PedReq = 1'b1;
    goto(13); chk("s3_ack_c13", PedAck, 0);
    goto(14); chk("s3_ack_c14", PedAck, 1); chk("s3_walk_c14", Walk, 1);
    goto(15); chk("s3_ack_c15", PedAck, 0);
    goto(19); chk("s3_walk_c19", Walk, 1);
    goto(20); chk("s3_walk_c20", Walk, 0);
    goto(21); chk("s3_ew_c21", EwLights, 3'b100);
    goto(22); chk("s3_ew_c22", EwLights, 3'b001);
    goto(40); PedReq = 1'b0;
    goto(45); chk("s3_ack_once", ack_cnt, 1);

    // Start dropped mid-green, then restarted.
    do_reset();
    Start = 1'b1;
    goto(3);  Start = 1'b0;
    goto(8);  chk("s4_ns_c8", NsLights, 3'b001);
    goto(9);  chk("s4_ns_c9", NsLights, 3'b010);
    goto(12); chk("s4_ns_c12", NsLights, 3'b100);
    goto(13); chk("s4_busy_c13", Busy, 1);
    goto(14); chk("s4_busy_c14", Busy, 0);
    goto(16); Start = 1'b1;
    goto(17); chk("s4_ew_c17", EwLights, 3'b001); chk("s4_ns_c17", NsLights, 3'b100);

    // Start=0 and a pending request meet at the same all-red exit.
    do_reset();
    Start = 1'b1;
    goto(10); Start = 1'b0; PedReq = 1'b1;
    goto(14); chk("s5_busy_c14", Busy, 0); chk("s5_walk_c14", Walk, 0);
    goto(16); Start = 1'b1;
    goto(17); chk("s5_walk_c17", Walk, 1); chk("s5_ack_c17", PedAck, 1);
    goto(18); chk("s5_ack_c18", PedAck, 0); PedReq = 1'b0;
    goto(25); chk("s5_ew_c25", EwLights, 3'b001);
    chk("s5_ack_once", ack_cnt, 1);

    // Reset during EW green with a request pending.
    do_reset();
    Start = 1'b1;
    goto(15); PedReq = 1'b1;
    goto(16); PedReq = 1'b0;
    goto(18); chk("s6_ew_c18", EwLights, 3'b001); Reset = 1'b1;
    goto(19); Reset = 1'b0;
    chk("s6_ew_c19", EwLights, 3'b100); chk("s6_ns_c19", NsLights, 3'b100);
    chk("s6_walk_c19", Walk, 0);
    goto(20); chk("s6_ns_c20", NsLights, 3'b001);
    goto(33); chk("s6_ew_c33", EwLights, 3'b001); chk("s6_walk_c33", Walk, 0);
    chk("s6_no_ack", ack_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
